// File: rtl/matmul_pkg.sv
// Shared types and elaboration helpers for the matrix-multiply sequencer.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD_A,
    RD_B,
    MAC,
    WR,
    ADV,
    DONE
  } state_e;

  function automatic int unsigned res_bytes(input int unsigned acc_w, input int unsigned dw);
    return acc_w / dw;
  endfunction

  function automatic bit widths_ok(input int unsigned acc_w, input int unsigned dw);
    return (dw != 0) && (acc_w >= dw) && ((acc_w % dw) == 0);
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matmul_engine_mac.sv
// Unsigned multiply-accumulate step: full-width product added to the running sum,
// with overflow detect and optional clamp to all-ones. Purely combinational.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned ACC_W    = 24,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [ACC_W-1:0] acc_c_o,
  output logic             ovf_c_o
);

  localparam int unsigned PROD_W = 2 * DW;
  localparam int unsigned SUM_W  = umax(ACC_W, PROD_W) + 1;

  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;

  always_comb begin
    prod    = PROD_W'(a_i) * PROD_W'(b_i);
    sum     = SUM_W'(acc_i) + SUM_W'(prod);
    ovf_c_o = |sum[SUM_W-1:ACC_W];
    if (ovf_c_o && SATURATE) begin
      acc_c_o = '1;
    end else begin
      acc_c_o = sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Matrix-multiply sequencer: walks A, B and C in data memory with running pointers,
// one MAC per three cycles, and writes each result little-endian over RB cycles.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DIM_W    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  dim_x_i,
  input  logic [DIM_W-1:0]  dim_y_i,
  input  logic [DIM_W-1:0]  dim_z_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W-1:0] base_c_i,
  output logic              dm_rd_en_o,
  output logic              dm_wr_en_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [DW-1:0]     dm_wdata_o,
  input  logic [DW-1:0]     dm_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o
);

  localparam int unsigned RB     = res_bytes(ACC_W, DW);
  localparam int unsigned BYTE_W = (RB > 1) ? $clog2(RB) : 1;

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(RB - 1);
  localparam logic [DIM_W-1:0]  ONE_D     = DIM_W'(1);
  localparam logic [BYTE_W-1:0] ONE_B     = BYTE_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  if (!widths_ok(ACC_W, DW)) begin : g_width_chk
    $error("matmul_engine: ACC_W must be a non-zero multiple of DW");
  end

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic [ADDR_W-1:0]  base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic [DIM_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DW-1:0]      a_reg_q, a_reg_d;
  logic [ADDR_W-1:0]  a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, c_ptr_q, c_ptr_d, row_q, row_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic               ovf_q, ovf_d;
  logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [ACC_W-1:0]   mac_acc;
  logic               mac_ovf;

  mac_unit #(
    .DW      (DW),
    .ACC_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .a_i    (a_reg_q),
    .b_i    (dm_rdata_i),
    .acc_i  (acc_q),
    .acc_c_o(mac_acc),
    .ovf_c_o(mac_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      a_reg_q  <= '0;
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      c_ptr_q  <= '0;
      row_q    <= '0;
      byte_q   <= '0;
      ovf_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      a_reg_q  <= a_reg_d;
      a_ptr_q  <= a_ptr_d;
      b_ptr_q  <= b_ptr_d;
      c_ptr_q  <= c_ptr_d;
      row_q    <= row_d;
      byte_q   <= byte_d;
      ovf_q    <= ovf_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    a_reg_d  = a_reg_q;
    a_ptr_d  = a_ptr_q;
    b_ptr_d  = b_ptr_q;
    c_ptr_d  = c_ptr_q;
    row_d    = row_q;
    byte_d   = byte_q;
    ovf_d    = ovf_q;
    rd_en_d  = 1'b0;
    wr_en_d  = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d      = dim_x_i;
          y_d      = dim_y_i;
          z_d      = dim_z_i;
          base_a_d = base_a_i;
          base_b_d = base_b_i;
          base_c_d = base_c_i;
          ovf_d    = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        acc_d   = '0;
        byte_d  = '0;
        a_ptr_d = base_a_q;
        row_d   = base_a_q;
        b_ptr_d = base_b_q;
        c_ptr_d = base_c_q;
        if (x_q == '0 || z_q == '0) begin
          state_d = DONE;
        end else if (y_q == '0) begin
          state_d = WR;
        end else begin
          state_d = RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_reg_d = dm_rdata_i;
        state_d = MAC;
      end
      MAC: begin
        acc_d   = mac_acc;
        ovf_d   = ovf_q | mac_ovf;
        a_ptr_d = a_ptr_q + ONE_A;
        b_ptr_d = b_ptr_q + ADDR_W'(z_q);
        if (k_q == y_q - ONE_D) begin
          byte_d  = '0;
          state_d = WR;
        end else begin
          k_d     = k_q + ONE_D;
          state_d = RD_A;
        end
      end
      WR: begin
        c_ptr_d = c_ptr_q + ONE_A;
        if (byte_q == LAST_BYTE) begin
          state_d = ADV;
        end else begin
          byte_d = byte_q + ONE_B;
        end
      end
      ADV: begin
        if (i_q == x_q - ONE_D && j_q == z_q - ONE_D) begin
          state_d = DONE;
        end else begin
          k_d    = '0;
          acc_d  = '0;
          byte_d = '0;
          // A row start only moves when j wraps to the next row of C
          if (j_q == z_q - ONE_D) begin
            j_d     = '0;
            i_d     = i_q + ONE_D;
            row_d   = row_q + ADDR_W'(y_q);
            a_ptr_d = row_d;
            b_ptr_d = base_b_q;
          end else begin
            j_d     = j_q + ONE_D;
            a_ptr_d = row_q;
            b_ptr_d = base_b_q + ADDR_W'(j_d);
          end
          state_d = (y_q == '0) ? WR : RD_A;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered
    rd_en_d = (state_d == RD_A) || (state_d == RD_B);
    wr_en_d = (state_d == WR);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    case (state_d)
      RD_A:    addr_d = a_ptr_d;
      RD_B:    addr_d = b_ptr_d;
      WR:      addr_d = c_ptr_d;
      default: addr_d = '0;
    endcase
    if (wr_en_d) begin
      wdata_d = DW'(acc_d >> (byte_d * DW));
    end
  end

  assign dm_rd_en_o = rd_en_q;
  assign dm_wr_en_o = wr_en_q;
  assign dm_addr_o  = addr_q;
  assign dm_wdata_o = wdata_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Bench for matmul_engine: three instances (24-bit wrap, 16-bit wrap, 16-bit saturate),
// each with its own byte memory, checked against an arithmetic reference model.
module tb_matmul_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start [3];
  logic [7:0]  dim_x, dim_y, dim_z;
  logic [15:0] base_a, base_b, base_c;
  logic        rd_en [3];
  logic        wr_en [3];
  logic [15:0] addr  [3];
  logic [7:0]  wdata [3];
  logic [7:0]  rdata [3];
  logic        busy  [3];
  logic        done  [3];
  logic        ovf   [3];

  matmul_engine #(.DW(8), .ACC_W(24), .ADDR_W(16), .DIM_W(8), .SATURATE(1'b0)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]),
    .dim_x_i(dim_x), .dim_y_i(dim_y), .dim_z_i(dim_z),
    .base_a_i(base_a), .base_b_i(base_b), .base_c_i(base_c),
    .dm_rd_en_o(rd_en[0]), .dm_wr_en_o(wr_en[0]), .dm_addr_o(addr[0]),
    .dm_wdata_o(wdata[0]), .dm_rdata_i(rdata[0]),
    .busy_o(busy[0]), .done_o(done[0]), .ovf_o(ovf[0]));

  matmul_engine #(.DW(8), .ACC_W(16), .ADDR_W(16), .DIM_W(8), .SATURATE(1'b0)) u_dut16w (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]),
    .dim_x_i(dim_x), .dim_y_i(dim_y), .dim_z_i(dim_z),
    .base_a_i(base_a), .base_b_i(base_b), .base_c_i(base_c),
    .dm_rd_en_o(rd_en[1]), .dm_wr_en_o(wr_en[1]), .dm_addr_o(addr[1]),
    .dm_wdata_o(wdata[1]), .dm_rdata_i(rdata[1]),
    .busy_o(busy[1]), .done_o(done[1]), .ovf_o(ovf[1]));

  matmul_engine #(.DW(8), .ACC_W(16), .ADDR_W(16), .DIM_W(8), .SATURATE(1'b1)) u_dut16s (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]),
    .dim_x_i(dim_x), .dim_y_i(dim_y), .dim_z_i(dim_z),
    .base_a_i(base_a), .base_b_i(base_b), .base_c_i(base_c),
    .dm_rd_en_o(rd_en[2]), .dm_wr_en_o(wr_en[2]), .dm_addr_o(addr[2]),
    .dm_wdata_o(wdata[2]), .dm_rdata_i(rdata[2]),
    .busy_o(busy[2]), .done_o(done[2]), .ovf_o(ovf[2]));

  // Data memories (1-cycle read latency) plus a bench load port; exp_mem is the reference image
  logic [7:0]  mem     [3][65536];
  logic [7:0]  exp_mem [3][65536];
  logic        ld_en = 1'b0;
  int          ld_inst = 0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;

  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (rd_en[n]) rdata[n] <= mem[n][addr[n]];
      if (wr_en[n]) mem[n][addr[n]] <= wdata[n];
    end
    if (ld_en) mem[ld_inst][ld_addr] <= ld_data;
  end

  int rd_cnt [3] = '{0, 0, 0};
  int wr_cnt [3] = '{0, 0, 0};
  int both_cnt [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (rd_en[n]) rd_cnt[n] <= rd_cnt[n] + 1;
      if (wr_en[n]) wr_cnt[n] <= wr_cnt[n] + 1;
      if (rd_en[n] && wr_en[n]) both_cnt[n] <= both_cnt[n] + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int n, input logic [15:0] a, input logic [7:0] d);
    ld_en   = 1'b1;
    ld_inst = n;
    ld_addr = a;
    ld_data = d;
    exp_mem[n][a] = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic rand_fill(input int n, input logic [15:0] base, input int cnt, input int lo);
    for (int i = 0; i < cnt; i++) poke(n, 16'(base + i), 8'($urandom_range(255, lo)));
  endtask

  // Straight definition of C = A*B, one MAC at a time, using the overflow rule of the mode
  task automatic model(input int n, input int x, input int y, input int z,
                       input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                       output bit ov);
    int     accw = (n == 0) ? 24 : 16;
    bit     sat  = (n == 2);
    int     rb   = accw / 8;
    longint lim  = longint'(1) << accw;
    longint acc;
    ov = 1'b0;
    for (int i = 0; i < x; i++) begin
      for (int j = 0; j < z; j++) begin
        acc = 0;
        for (int k = 0; k < y; k++) begin
          acc += longint'(exp_mem[n][16'(ba + i * y + k)]) * longint'(exp_mem[n][16'(bb + k * z + j)]);
          if (acc >= lim) begin
            ov  = 1'b1;
            acc = sat ? lim - 1 : acc % lim;
          end
        end
        for (int b = 0; b < rb; b++) exp_mem[n][16'(bc + (i * z + j) * rb + b)] = 8'(acc >> (8 * b));
      end
    end
  endtask

  task automatic run_job(input string tag, input int n, input int x, input int y, input int z,
                         input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                         input bit hammer);
    int rb = (n == 0) ? 3 : 2;
    int nb = x * z * rb;
    int exp_lat = (x == 0 || z == 0) ? 1 : 1 + x * z * (3 * y + rb + 1);
    int exp_rd  = (x == 0 || z == 0) ? 0 : 2 * x * y * z;
    int lat, rd0, wr0, both0;
    bit exp_ovf;
    poke(n, 16'(bc - 1), 8'h5A);
    for (int b = 0; b < nb; b++) poke(n, 16'(bc + b), 8'hAA);
    poke(n, 16'(bc + nb), 8'h5A);
    model(n, x, y, z, ba, bb, bc, exp_ovf);
    dim_x = 8'(x); dim_y = 8'(y); dim_z = 8'(z);
    base_a = ba; base_b = bb; base_c = bc;
    rd0 = rd_cnt[n]; wr0 = wr_cnt[n]; both0 = both_cnt[n];
    start[n] = 1'b1;
    tick();
    start[n] = hammer;
    check({tag, "_busy_setup"}, 64'(busy[n]), 64'd1);
    check({tag, "_ovf_cleared"}, 64'(ovf[n]), 64'd0);
    lat = 0;
    while (!done[n] && lat < 5000) begin
      tick();
      lat++;
      if (hammer) start[n] = ~start[n];
    end
    start[n] = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_ovf"}, 64'(ovf[n]), 64'(exp_ovf));
    tick();
    check({tag, "_done_pulse"}, 64'(done[n]), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy[n]), 64'd0);
    if (hammer) begin
      repeat (4) tick();
      check({tag, "_no_second_job"}, 64'(busy[n]), 64'd0);
    end
    check({tag, "_rd_count"}, 64'(rd_cnt[n] - rd0), 64'(exp_rd));
    check({tag, "_wr_count"}, 64'(wr_cnt[n] - wr0), 64'(nb));
    check({tag, "_rd_wr_excl"}, 64'(both_cnt[n] - both0), 64'd0);
    for (int b = -1; b <= nb; b++)
      check($sformatf("%s_c%0d", tag, b), 64'(mem[n][16'(bc + b)]), 64'(exp_mem[n][16'(bc + b)]));
  endtask

  int wseen, wr0, cyc;

  initial begin
    for (int n = 0; n < 3; n++) start[n] = 1'b0;
    dim_x = '0; dim_y = '0; dim_z = '0;
    base_a = '0; base_b = '0; base_c = '0;
    rst_n = 1'b0;
    #12;
    check("reset_rd_en", 64'(rd_en[0]), 64'd0);
    check("reset_wr_en", 64'(wr_en[0]), 64'd0);
    check("reset_addr", 64'(addr[0]), 64'd0);
    check("reset_wdata", 64'(wdata[0]), 64'd0);
    check("reset_busy", 64'(busy[0]), 64'd0);
    check("reset_done", 64'(done[0]), 64'd0);
    check("reset_ovf", 64'(ovf[0]), 64'd0);
    rst_n = 1'b1;
    tick();

    // 2x2 by 2x2 reference case
    poke(0, 16'h10, 1); poke(0, 16'h11, 2); poke(0, 16'h12, 3); poke(0, 16'h13, 4);
    poke(0, 16'h20, 5); poke(0, 16'h21, 6); poke(0, 16'h22, 7); poke(0, 16'h23, 8);
    run_job("t1", 0, 2, 2, 2, 16'h10, 16'h20, 16'h40, 1'b0);
    check("t1_c00", 64'(mem[0][16'h40]), 64'd19);
    check("t1_c01", 64'(mem[0][16'h43]), 64'd22);
    check("t1_c10", 64'(mem[0][16'h46]), 64'd43);
    check("t1_c11", 64'(mem[0][16'h49]), 64'd50);

    // 16-bit accumulator overflow, wrap and saturate
    for (int n = 1; n < 3; n++) begin
      poke(n, 16'h00, 8'hFF); poke(n, 16'h01, 8'hFF);
      poke(n, 16'h10, 8'hFF); poke(n, 16'h11, 8'hFF);
    end
    run_job("t2w", 1, 1, 2, 1, 16'h00, 16'h10, 16'h20, 1'b0);
    run_job("t2s", 2, 1, 2, 1, 16'h00, 16'h10, 16'h20, 1'b0);
    check("t2w_lo", 64'(mem[1][16'h20]), 64'h02);
    check("t2w_hi", 64'(mem[1][16'h21]), 64'hFC);
    check("t2w_ovf", 64'(ovf[1]), 64'd1);
    check("t2s_lo", 64'(mem[2][16'h20]), 64'hFF);
    check("t2s_hi", 64'(mem[2][16'h21]), 64'hFF);
    check("t2s_ovf", 64'(ovf[2]), 64'd1);

    // Degenerate dimensions
    run_job("t3x0", 0, 0, 3, 3, 16'h10, 16'h20, 16'h80, 1'b0);
    run_job("t3y0", 0, 2, 0, 2, 16'h10, 16'h20, 16'h90, 1'b0);
    check("t3y0_last", 64'(mem[0][16'h9B]), 64'd0);

    // Non-square job with start held/toggled while busy
    poke(0, 16'h100, 1); poke(0, 16'h101, 2); poke(0, 16'h102, 3);
    poke(0, 16'h110, 1); poke(0, 16'h111, 0); poke(0, 16'h112, 0);
    poke(0, 16'h113, 1); poke(0, 16'h114, 1); poke(0, 16'h115, 1);
    run_job("t4", 0, 1, 3, 2, 16'h100, 16'h110, 16'h120, 1'b1);
    check("t4_c0", 64'(mem[0][16'h120]), 64'd4);
    check("t4_c1", 64'(mem[0][16'h123]), 64'd5);

    // Abort with reset during the second result byte
    for (int b = 0; b < 12; b++) poke(0, 16'(16'h40 + b), 8'hAA);
    dim_x = 8'd2; dim_y = 8'd2; dim_z = 8'd2;
    base_a = 16'h10; base_b = 16'h20; base_c = 16'h40;
    wr0 = wr_cnt[0];
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wseen = 0;
    cyc = 0;
    while (cyc < 200) begin
      if (wr_en[0]) begin
        wseen++;
        if (wseen == 2) break;
      end
      tick();
      cyc++;
    end
    check("t5_second_wr_seen", 64'(wseen), 64'd2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_wr_en", 64'(wr_en[0]), 64'd0);
    check("t5_rst_rd_en", 64'(rd_en[0]), 64'd0);
    check("t5_rst_busy", 64'(busy[0]), 64'd0);
    check("t5_rst_addr", 64'(addr[0]), 64'd0);
    check("t5_rst_wdata", 64'(wdata[0]), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t5_wr_count", 64'(wr_cnt[0] - wr0), 64'd1);
    check("t5_byte0", 64'(mem[0][16'h40]), 64'd19);
    check("t5_byte1_untouched", 64'(mem[0][16'h41]), 64'hAA);
    check("t5_idle", 64'(busy[0]), 64'd0);
    run_job("t5re", 0, 2, 2, 2, 16'h10, 16'h20, 16'h40, 1'b0);

    // Result straddling the top of the address space
    poke(0, 16'h200, 8'hFF); poke(0, 16'h201, 8'hFF);
    poke(0, 16'h210, 8'hFF); poke(0, 16'h211, 8'hFF);
    run_job("t6", 0, 1, 2, 1, 16'h200, 16'h210, 16'hFFFE, 1'b0);
    check("t6_b0", 64'(mem[0][16'hFFFE]), 64'h02);
    check("t6_b1", 64'(mem[0][16'hFFFF]), 64'hFC);
    check("t6_b2_wrapped", 64'(mem[0][16'h0000]), 64'h01);

    // Random jobs across all three flavours
    for (int r = 0; r < 9; r++) begin
      int n = r % 3;
      int x = $urandom_range(4, 1);
      int y = $urandom_range(4, 0);
      int z = $urandom_range(4, 1);
      logic [15:0] ba = 16'(16'h1000 + $urandom_range(255, 0));
      logic [15:0] bb = 16'(16'h2000 + $urandom_range(255, 0));
      logic [15:0] bc = 16'(16'h3000 + $urandom_range(255, 0));
      rand_fill(n, ba, x * y, (n == 0) ? 0 : 128);
      rand_fill(n, bb, y * z, (n == 0) ? 0 : 128);
      run_job($sformatf("rnd%0d", r), n, x, y, z, ba, bb, bc, r[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
